// File: rtl/memory_controller_pkg.sv
// Shared encodings and helpers for the unified byte-wide memory controller.
package memory_controller_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic        TRUE      = 1'b1;
  localparam logic        FALSE     = 1'b0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_t;

  typedef enum logic {
    OWNER_IF,
    OWNER_LSB
  } owner_t;

  // Byte count for an access size; the illegal encoding behaves as a word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      SIZE_W:  return 3'd4;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memory_controller_byte_lane_assembler.sv
// Byte counter plus 4x8 little-endian assembly buffer shared by both requesters.
module memory_controller_byte_lane_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        step,
  input  logic [7:0]  din,
  output logic [2:0]  count,
  output logic [31:0] word_next
);

  logic [3:0][7:0] lanes;
  logic [3:0][7:0] lanes_nx;
  logic [1:0]      lane;

  // Read data trails its address by one cycle, so lane k fills on step k+1.
  always_comb begin
    lanes_nx = lanes;
    lane     = count[1:0] - 2'd1;
    if (step && (count != 3'd0)) lanes_nx[lane] = din;
  end

  assign word_next = lanes_nx;

  // Counter and buffer; clear wins over step so a finishing access leaves both at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      lanes <= '0;
    end else if (clear) begin
      count <= '0;
      lanes <= '0;
    end else if (step) begin
      count <= count + 3'd1;
      lanes <= lanes_nx;
    end
  end

endmodule

// File: rtl/memory_controller.sv
// Sole owner of the byte-wide RAM port; serialises fetch and load/store accesses.
module memory_controller
  import memory_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  if_request_in,
  input  logic [ADDR_WIDTH-1:0] if_address_in,
  output logic                  if_ready_out,
  output logic [31:0]           if_instruction_out,
  input  logic                  lsb_request_in,
  input  logic                  lsb_write_in,
  input  logic [1:0]            lsb_size_in,
  input  logic [ADDR_WIDTH-1:0] lsb_address_in,
  input  logic [31:0]           lsb_data_in,
  output logic                  lsb_ready_out,
  output logic [31:0]           lsb_data_out,
  input  logic                  rob_rollback_in
);

  state_t                state, state_nx;
  owner_t                owner, owner_nx;
  logic [2:0]            n_bytes, n_nx, n_last;
  logic                  fetch_pending, pend_nx, fetch_take;
  logic [ADDR_WIDTH-1:0] fetch_addr, faddr_nx, mem_a_nx;
  logic                  mem_wr_nx, if_ready_nx, lsb_ready_nx;
  logic [7:0]            mem_dout_nx;
  logic [31:0]           if_instr_nx, lsb_data_nx, word_next;
  logic                  asm_clear, asm_step;
  logic [2:0]            count;
  logic [3:0][7:0]       store_bytes;
  logic [1:0]            next_lane;

  assign store_bytes = lsb_data_in;
  assign n_last      = n_bytes - 3'd1;
  assign next_lane   = count[1:0] + 2'd1;

  memory_controller_byte_lane_assembler u_lanes (
    .clk       (clk),
    .rst       (rst),
    .clear     (asm_clear),
    .step      (asm_step),
    .din       (mem_din),
    .count     (count),
    .word_next (word_next)
  );

  // Registered state and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= ST_IDLE;
      owner              <= OWNER_IF;
      n_bytes            <= '0;
      fetch_pending      <= FALSE;
      fetch_addr         <= '0;
      mem_a              <= '0;
      mem_wr             <= FALSE;
      mem_dout           <= '0;
      if_ready_out       <= FALSE;
      if_instruction_out <= ZERO_WORD;
      lsb_ready_out      <= FALSE;
      lsb_data_out       <= ZERO_WORD;
    end else begin
      state              <= state_nx;
      owner              <= owner_nx;
      n_bytes            <= n_nx;
      fetch_pending      <= pend_nx;
      fetch_addr         <= faddr_nx;
      mem_a              <= mem_a_nx;
      mem_wr             <= mem_wr_nx;
      mem_dout           <= mem_dout_nx;
      if_ready_out       <= if_ready_nx;
      if_instruction_out <= if_instr_nx;
      lsb_ready_out      <= lsb_ready_nx;
      lsb_data_out       <= lsb_data_nx;
    end
  end

  // Arbitration, byte sequencing, completion and fetch-pending bookkeeping.
  always_comb begin
    state_nx     = state;
    owner_nx     = owner;
    n_nx         = n_bytes;
    mem_a_nx     = mem_a;
    mem_wr_nx    = mem_wr;
    mem_dout_nx  = mem_dout;
    if_ready_nx  = FALSE;
    if_instr_nx  = if_instruction_out;
    lsb_ready_nx = FALSE;
    lsb_data_nx  = lsb_data_out;
    asm_clear    = FALSE;
    asm_step     = FALSE;
    fetch_take   = FALSE;
    pend_nx      = fetch_pending;
    faddr_nx     = fetch_addr;

    unique case (state)
      ST_IDLE: begin
        mem_wr_nx = FALSE;
        if (lsb_request_in) begin
          owner_nx  = OWNER_LSB;
          n_nx      = byte_count(lsb_size_in);
          mem_a_nx  = lsb_address_in;
          asm_clear = TRUE;
          if (lsb_write_in) begin
            state_nx    = ST_WRITE;
            mem_wr_nx   = TRUE;
            mem_dout_nx = store_bytes[0];
          end else begin
            state_nx = ST_READ;
          end
        end else if (!rob_rollback_in && (fetch_pending || if_request_in)) begin
          owner_nx   = OWNER_IF;
          n_nx       = byte_count(SIZE_W);
          mem_a_nx   = fetch_pending ? fetch_addr : if_address_in;
          asm_clear  = TRUE;
          fetch_take = TRUE;
          state_nx   = ST_READ;
        end
      end
      ST_READ: begin
        if ((owner == OWNER_IF) && rob_rollback_in) begin
          state_nx  = ST_IDLE;
          asm_clear = TRUE;
        end else begin
          // Step also on the final edge so word_next includes the last lane.
          asm_step = TRUE;
          if (count < n_last) mem_a_nx = mem_a + ADDR_WIDTH'(1);
          if (count == n_bytes) begin
            state_nx  = ST_IDLE;
            asm_clear = TRUE;
            if (owner == OWNER_IF) begin
              if_ready_nx = TRUE;
              if_instr_nx = word_next;
            end else begin
              lsb_ready_nx = TRUE;
              lsb_data_nx  = word_next;
            end
          end
        end
      end
      ST_WRITE: begin
        if (count < n_last) begin
          asm_step    = TRUE;
          mem_a_nx    = mem_a + ADDR_WIDTH'(1);
          mem_dout_nx = store_bytes[next_lane];
        end else begin
          mem_wr_nx    = FALSE;
          lsb_ready_nx = TRUE;
          state_nx     = ST_IDLE;
          asm_clear    = TRUE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    // A pulse arriving while busy (or losing arbitration) is remembered for later.
    if (rob_rollback_in) begin
      pend_nx = FALSE;
    end else begin
      if (fetch_take) pend_nx = FALSE;
      if (if_request_in && !(fetch_take && !fetch_pending)) begin
        pend_nx  = TRUE;
        faddr_nx = if_address_in;
      end
    end
  end

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller against a byte-array reference model.
module tb_memory_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_request_in = 1'b0;
  logic [31:0] if_address_in = '0;
  logic        if_ready_out;
  logic [31:0] if_instruction_out;
  logic        lsb_request_in = 1'b0;
  logic        lsb_write_in = 1'b0;
  logic [1:0]  lsb_size_in = '0;
  logic [31:0] lsb_address_in = '0;
  logic [31:0] lsb_data_in = '0;
  logic        lsb_ready_out;
  logic [31:0] lsb_data_out;
  logic        rob_rollback_in = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  memory_controller #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .if_request_in(if_request_in), .if_address_in(if_address_in),
    .if_ready_out(if_ready_out), .if_instruction_out(if_instruction_out),
    .lsb_request_in(lsb_request_in), .lsb_write_in(lsb_write_in), .lsb_size_in(lsb_size_in),
    .lsb_address_in(lsb_address_in), .lsb_data_in(lsb_data_in), .lsb_ready_out(lsb_ready_out),
    .lsb_data_out(lsb_data_out), .rob_rollback_in(rob_rollback_in)
  );

  always #5 clk = ~clk;

  // Synchronous RAM (4 KiB, aliased): read data appears the cycle after the address.
  logic [7:0] ram [0:4095];
  logic [7:0] ref_mem [0:4095];
  logic       ram_loaded = 1'b0;

  function automatic logic [7:0] seed_byte(input int unsigned i);
    return 8'((i * 37 + 11) ^ (i >> 3));
  endfunction

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 4096; i++) ram[i] <= seed_byte(i);
      ram_loaded <= 1'b1;
    end else begin
      mem_din <= ram[mem_a[11:0]];
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    end
  end

  // Reference model: plain byte-array arithmetic.
  function automatic int unsigned nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a, input int unsigned n);
    logic [31:0] w = '0;
    for (int unsigned k = 0; k < n; k++) w[8*k +: 8] = ref_mem[12'(a + k)];
    return w;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) ref_mem[12'(a + k)] = d[8*k +: 8];
  endfunction

  // Per-cycle observations of the RAM port, index 0 = capture edge.
  logic [31:0] obs_a  [16];
  logic        obs_wr [16];
  logic [7:0]  obs_do [16];
  int          obs_n;
  logic        timed_out;

  task automatic run_lsb(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] data, input int rb_cycle);
    lsb_request_in = 1'b1; lsb_write_in = wr; lsb_size_in = size;
    lsb_address_in = addr; lsb_data_in = data;
    obs_n = 0; timed_out = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      rob_rollback_in = 1'b0;
      obs_a[c] = mem_a; obs_wr[c] = mem_wr; obs_do[c] = mem_dout; obs_n = c + 1;
      if (c == rb_cycle) rob_rollback_in = 1'b1;
      if (lsb_ready_out) begin timed_out = 1'b0; break; end
    end
    lsb_request_in = 1'b0; rob_rollback_in = 1'b0;
  endtask

  task automatic run_fetch(input logic [31:0] addr, input int rb_cycle);
    if_request_in = 1'b1; if_address_in = addr;
    obs_n = 0; timed_out = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if_request_in = 1'b0; rob_rollback_in = 1'b0;
      obs_a[c] = mem_a; obs_wr[c] = mem_wr; obs_do[c] = mem_dout; obs_n = c + 1;
      if (c == rb_cycle) rob_rollback_in = 1'b1;
      if (if_ready_out) begin timed_out = 1'b0; break; end
    end
    rob_rollback_in = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4096; i++) ref_mem[i] = seed_byte(i);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if ({if_ready_out, lsb_ready_out} !== 2'b00) begin n_bad++;
      $display("FAIL reset_ready: got %b expected 00", {if_ready_out, lsb_ready_out}); end
    n_vec++; if ({mem_wr, mem_dout, mem_a} !== 41'd0) begin n_bad++;
      $display("FAIL reset_port: got wr=%b dout=%h a=%h expected zeros", mem_wr, mem_dout, mem_a); end
    n_vec++; if ({if_instruction_out, lsb_data_out} !== 64'd0) begin n_bad++;
      $display("FAIL reset_data: got %h/%h expected 0/0", if_instruction_out, lsb_data_out); end
    #3 rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fetch();
    int lat;
    logic wr_seen;
    run_lsb(1'b1, 2'b10, 32'h100, 32'h0010_0513, -1);
    ref_write(32'h100, 32'h0010_0513, 4);
    n_vec++; if (timed_out || obs_n - 1 != 4) begin n_bad++;
      $display("FAIL fetch_setup_store_latency: got %0d expected 4", obs_n - 1); end
    run_fetch(32'h100, -1);
    lat = obs_n - 1;
    n_vec++; if (timed_out !== 1'b0 || lat != 5) begin n_bad++;
      $display("FAIL fetch_latency: got %0d (timeout %b) expected 5", lat, timed_out); end
    n_vec++; if (if_instruction_out !== 32'h0010_0513) begin n_bad++;
      $display("FAIL fetch_data: got %h expected 00100513", if_instruction_out); end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (obs_a[k] !== 32'h100 + 32'(k)) begin n_bad++;
        $display("FAIL fetch_addr%0d: got %h expected %h", k, obs_a[k], 32'h100 + 32'(k)); end
    end
    wr_seen = 1'b0;
    for (int k = 0; k < obs_n; k++) wr_seen |= obs_wr[k];
    n_vec++; if (wr_seen !== 1'b0) begin n_bad++;
      $display("FAIL fetch_no_write: got %b expected 0", wr_seen); end
    @(posedge clk); #1;
    n_vec++; if (if_ready_out !== 1'b0 || if_instruction_out !== 32'h0010_0513) begin n_bad++;
      $display("FAIL fetch_pulse_hold: got ready=%b data=%h expected 0/00100513", if_ready_out, if_instruction_out); end
  endtask

  task automatic test_byte_store();
    run_lsb(1'b1, 2'b00, 32'h20, 32'hDEAD_BEEF, -1);
    ref_write(32'h20, 32'hDEAD_BEEF, 1);
    n_vec++; if (timed_out || obs_n - 1 != 1) begin n_bad++;
      $display("FAIL bstore_latency: got %0d expected 1", obs_n - 1); end
    n_vec++; if ({obs_wr[0], obs_a[0], obs_do[0]} !== {1'b1, 32'h20, 8'hEF}) begin n_bad++;
      $display("FAIL bstore_beat: got wr=%b a=%h d=%h expected 1/20/ef", obs_wr[0], obs_a[0], obs_do[0]); end
    n_vec++; if (obs_wr[1] !== 1'b0) begin n_bad++;
      $display("FAIL bstore_single_strobe: got %b expected 0", obs_wr[1]); end
    @(posedge clk); #1;
    n_vec++; if (lsb_ready_out !== 1'b0) begin n_bad++;
      $display("FAIL bstore_pulse: got %b expected 0", lsb_ready_out); end
  endtask

  task automatic test_half_load();
    run_lsb(1'b1, 2'b01, 32'h41, 32'hFFFF_1234, -1);
    ref_write(32'h41, 32'hFFFF_1234, 2);
    n_vec++; if (timed_out || obs_n - 1 != 2) begin n_bad++;
      $display("FAIL hstore_latency: got %0d expected 2", obs_n - 1); end
    run_lsb(1'b0, 2'b01, 32'h41, $urandom, -1);
    n_vec++; if (timed_out || obs_n - 1 != 3) begin n_bad++;
      $display("FAIL hload_latency: got %0d expected 3", obs_n - 1); end
    n_vec++; if (lsb_data_out !== 32'h0000_1234) begin n_bad++;
      $display("FAIL hload_data: got %h expected 00001234", lsb_data_out); end
    n_vec++; if ({obs_wr[0], obs_wr[1], obs_wr[2], obs_a[0], obs_a[1]} !== {3'b000, 32'h41, 32'h42}) begin n_bad++;
      $display("FAIL hload_port: got wr=%b%b%b a=%h,%h expected 000 41,42", obs_wr[0], obs_wr[1], obs_wr[2], obs_a[0], obs_a[1]); end
  endtask

  task automatic test_arbitration();
    int lsb_at, if_at;
    logic [31:0] got_l, got_i, fetch_a, exp_l, exp_i;
    logic wr_seen;
    exp_l = ref_read(32'h80, 4);
    exp_i = ref_read(32'h100, 4);
    lsb_at = -1; if_at = -1; got_l = '0; got_i = '0; fetch_a = '0; wr_seen = 1'b0;
    lsb_request_in = 1'b1; lsb_write_in = 1'b0; lsb_size_in = 2'b10; lsb_address_in = 32'h80;
    if_request_in = 1'b1; if_address_in = 32'h100;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if_request_in = 1'b0;
      wr_seen |= mem_wr;
      if (lsb_at >= 0 && c == lsb_at + 1) fetch_a = mem_a;
      if (lsb_ready_out && lsb_at < 0) begin lsb_at = c; got_l = lsb_data_out; lsb_request_in = 1'b0; end
      if (if_ready_out) begin if_at = c; got_i = if_instruction_out; break; end
    end
    lsb_request_in = 1'b0;
    n_vec++; if (lsb_at != 5 || got_l !== exp_l) begin n_bad++;
      $display("FAIL arb_lsb: got cycle %0d data %h expected 5 %h", lsb_at, got_l, exp_l); end
    n_vec++; if (if_at != 11 || got_i !== exp_i) begin n_bad++;
      $display("FAIL arb_fetch: got cycle %0d data %h expected 11 %h", if_at, got_i, exp_i); end
    n_vec++; if (fetch_a !== 32'h100 || wr_seen !== 1'b0) begin n_bad++;
      $display("FAIL arb_port: got a=%h wr=%b expected 100/0", fetch_a, wr_seen); end
  endtask

  task automatic test_rollback();
    logic wr_seen;
    run_fetch(32'h200, 1);
    wr_seen = 1'b0;
    for (int k = 0; k < obs_n; k++) wr_seen |= obs_wr[k];
    n_vec++; if (timed_out !== 1'b1) begin n_bad++;
      $display("FAIL rollback_no_ready: got ready after %0d cycles expected none", obs_n - 1); end
    n_vec++; if (wr_seen !== 1'b0) begin n_bad++;
      $display("FAIL rollback_no_write: got %b expected 0", wr_seen); end
    run_fetch(32'h300, -1);
    n_vec++; if (timed_out || obs_n - 1 != 5 || if_instruction_out !== ref_read(32'h300, 4)) begin n_bad++;
      $display("FAIL rollback_next_fetch: got lat %0d data %h expected 5 %h", obs_n - 1, if_instruction_out, ref_read(32'h300, 4)); end
  endtask

  task automatic test_reset_mid_store();
    logic wr_seen;
    lsb_request_in = 1'b1; lsb_write_in = 1'b1; lsb_size_in = 2'b10;
    lsb_address_in = 32'h500; lsb_data_in = 32'hA5C3_3C5A;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++; if (mem_wr !== 1'b1) begin n_bad++;
      $display("FAIL midreset_store_active: got %b expected 1", mem_wr); end
    #3 rst = 1'b0;
    #1;
    n_vec++; if ({mem_wr, if_ready_out, lsb_ready_out} !== 3'b000) begin n_bad++;
      $display("FAIL midreset_async: got %b expected 000", {mem_wr, if_ready_out, lsb_ready_out}); end
    lsb_request_in = 1'b0;
    @(posedge clk); #3 rst = 1'b1;
    wr_seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; wr_seen |= mem_wr; end
    n_vec++; if (wr_seen !== 1'b0) begin n_bad++;
      $display("FAIL midreset_idle: got wr %b expected 0", wr_seen); end
    for (int k = 0; k < 4; k++) ref_mem[12'h500 + k] = ram[12'h500 + k];
    run_lsb(1'b0, 2'b00, 32'h600, '0, -1);
    n_vec++; if (timed_out || obs_n - 1 != 2 || lsb_data_out !== ref_read(32'h600, 1)) begin n_bad++;
      $display("FAIL midreset_after_load: got lat %0d data %h expected 2 %h", obs_n - 1, lsb_data_out, ref_read(32'h600, 1)); end
  endtask

  task automatic test_random();
    int unsigned op, n;
    logic [1:0]  size;
    logic [31:0] addr, data, exp;
    logic        ok;
    for (int it = 0; it < 60; it++) begin
      op   = $urandom_range(0, 2);
      size = 2'($urandom_range(0, 3));
      addr = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3) : $urandom_range(0, 4095);
      data = $urandom;
      ok   = 1'b1;
      if (op == 2) begin
        exp = ref_read(addr, 4);
        run_fetch(addr, -1);
        if (timed_out || obs_n - 1 != 5 || if_instruction_out !== exp) ok = 1'b0;
        for (int k = 0; k < 4; k++) if (obs_a[k] !== addr + 32'(k) || obs_wr[k] !== 1'b0) ok = 1'b0;
        n_vec++; if (!ok) begin n_bad++;
          $display("FAIL rand_fetch[%0d] a=%h: got lat %0d data %h expected 5 %h", it, addr, obs_n - 1, if_instruction_out, exp); end
      end else begin
        n = nbytes(size);
        exp = ref_read(addr, n);
        run_lsb(op == 1, size, addr, data, ($urandom_range(0, 3) == 0) ? 1 : -1);
        if (op == 1) begin
          if (timed_out || obs_n - 1 != int'(n) || obs_wr[n] !== 1'b0) ok = 1'b0;
          for (int unsigned k = 0; k < n; k++)
            if ({obs_wr[k], obs_a[k], obs_do[k]} !== {1'b1, addr + k, data[8*k +: 8]}) ok = 1'b0;
          ref_write(addr, data, n);
          n_vec++; if (!ok) begin n_bad++;
            $display("FAIL rand_store[%0d] a=%h size=%0d: got lat %0d expected %0d with %0d byte strobes", it, addr, size, obs_n - 1, n, n); end
        end else begin
          if (timed_out || obs_n - 1 != int'(n) + 1 || lsb_data_out !== exp) ok = 1'b0;
          for (int unsigned k = 0; k < n; k++) if (obs_a[k] !== addr + k) ok = 1'b0;
          for (int k = 0; k < obs_n; k++) if (obs_wr[k] !== 1'b0) ok = 1'b0;
          n_vec++; if (!ok) begin n_bad++;
            $display("FAIL rand_load[%0d] a=%h size=%0d: got lat %0d data %h expected %0d %h", it, addr, size, obs_n - 1, lsb_data_out, n + 1, exp); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_byte_store();
    test_half_load();
    test_arbitration();
    test_rollback();
    test_reset_mid_store();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
